// File: rtl/serial_word_loader_pkg.sv
// Shared constants, state encoding and pin map for serial_word_loader.
// Define SERIAL_WORD_LOADER_PARITY_EN to add a trailing even-parity bit to each frame.
package serial_word_loader_pkg;

  localparam int DATA_W = 6;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILL,
    S_FULL,
    S_ERROR
  } state_e;

  localparam int PIN_CLK   = 0;
  localparam int PIN_RST   = 1;
  localparam int PIN_SDATA = 2;
  localparam int PIN_SHIFT = 3;
  localparam int PIN_LOAD  = 4;
  localparam int PIN_CLEAR = 5;

endpackage

// File: rtl/serial_word_loader_if.sv
// 8-in/8-out tile pinout shared by every project in the codebase.
interface serial_word_loader_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/serial_word_loader_shift_count.sv
// Frame shift register with a saturating bit counter; flags full and overrun.
module loader_shift_count
  import serial_word_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               restart_i,
  input  logic               sdata_i,
  output logic [FRAME_W-1:0] sreg_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               full_o,
  output logic               overrun_o
);

  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  assign full_o    = (cnt_q == CNT_W'(FRAME_W));
  assign overrun_o = shift_i && !restart_i && full_o;
  assign sreg_o    = sreg_q;
  assign cnt_o     = cnt_q;

  // restart_i starts a new frame; a coincident shift becomes its first bit.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      sreg_d = '0;
      cnt_d  = '0;
    end else begin
      if (shift_i) begin
        sreg_d = {sreg_q[FRAME_W-2:0], sdata_i};
      end
      if (restart_i) begin
        cnt_d = shift_i ? CNT_W'(1) : '0;
      end else if (shift_i && !full_o) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel operand loader: framing FSM, optional parity check, registered outputs.
// Build option: SERIAL_WORD_LOADER_PARITY_EN enables the 7-bit frame with even parity.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int DATA_W = 6
) (
  serial_word_loader_if.slave pins
);

  logic clk, rst, sdata, shift, load, clear;
  assign clk   = pins.io_in[PIN_CLK];
  assign rst   = pins.io_in[PIN_RST];
  assign sdata = pins.io_in[PIN_SDATA];
  assign shift = pins.io_in[PIN_SHIFT];
  assign load  = pins.io_in[PIN_LOAD];
  assign clear = pins.io_in[PIN_CLEAR];

  logic unused_pins;
  assign unused_pins = ^pins.io_in[7:6];

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [FRAME_W-1:0] sreg;
  logic [CNT_W-1:0]   cnt;
  logic               full, overrun;
  logic               parity_ok, accept, active, restart, sh_en;

`ifdef SERIAL_WORD_LOADER_PARITY_EN
  assign parity_ok = ~^sreg;
`else
  assign parity_ok = 1'b1;
`endif

  assign accept  = full && parity_ok;
  assign active  = (state_q != S_ERROR) && !clear;
  assign restart = active && load && accept;
  // A failed load wins over a coincident shift; a good load lets it through.
  assign sh_en   = active && shift && (!load || accept);

  loader_shift_count u_shift_count (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .shift_i   (sh_en),
    .restart_i (restart),
    .sdata_i   (sdata),
    .sreg_o    (sreg),
    .cnt_o     (cnt),
    .full_o    (full),
    .overrun_o (overrun)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (clear) begin
      state_d = S_EMPTY;
      word_d  = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (state_q != S_ERROR) begin
      if (load) begin
        if (accept) begin
          word_d  = sreg[FRAME_W-1 -: DATA_W];
          valid_d = 1'b1;
          state_d = shift ? S_FILL : S_EMPTY;
        end else begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = S_ERROR;
        end
      end else if (shift) begin
        if (overrun) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else if (cnt == CNT_W'(FRAME_W - 1)) begin
          state_d = S_FULL;
        end else begin
          state_d = S_FILL;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign pins.io_out = {err_q, valid_q, word_q};

endmodule
